// File: rtl/nibbler_sync_ram.sv
// Clocked single-port data RAM for the Nibbler: registered read port, valid/oe strobe,
// and an optional post-reset sequencer that zeroes every word before accepting commands.
module nibbler_sync_ram #(
    parameter int DATA_W         = 4,
    parameter int ADDR_W         = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] add,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              oe,
    output logic              busy
);

    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic ST_CLEAR = 1'b0;
    localparam logic ST_IDLE  = 1'b1;
    localparam logic ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    logic              state;
    logic [ADDR_W-1:0] clr_cnt;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    logic              rd_en;
    logic              wr_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign busy = (state == ST_CLEAR);

    // Clear sequencer: one word per cycle, leaves CLEAR on the edge that writes the last word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_RESET;
            clr_cnt <= '0;
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + 1'b1;
            if (clr_cnt == {ADDR_W{1'b1}}) begin
                state <= ST_IDLE;
            end
        end
    end

    assign rd_en = !busy && cs && !we;
    assign wr_en = !busy && cs && we && reset_n;

    // Clearing and user writes share one write port so the array maps onto a block RAM.
    assign mem_we    = (busy && reset_n) || wr_en;
    assign mem_waddr = busy ? clr_cnt : add;
    assign mem_wdata = busy ? '0 : din;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else if (rd_en) begin
            dout       <= mem[add];
            dout_valid <= 1'b1;
        end else begin
            dout_valid <= 1'b0;
        end
    end

    assign oe = dout_valid;

    // An unknown chip select or write enable while accepting commands means the control ROM misbehaved.
    always @(posedge clk) begin
        if (reset_n && !busy) begin
            assert (!$isunknown({cs, we}));
        end
    end

endmodule

// File: tb/tb_nibbler_sync_ram.sv
// Directed bench for nibbler_sync_ram: clearing instance with a read scoreboard,
// plus a non-clearing instance for contents surviving reset.
module tb_nibbler_sync_ram;

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        we;
    logic [11:0] add;
    logic [3:0]  din;
    logic [3:0]  dout;
    logic        dout_valid;
    logic        oe;
    logic        busy;

    logic        b_reset_n;
    logic        b_cs;
    logic        b_we;
    logic [11:0] b_add;
    logic [3:0]  b_din;
    logic [3:0]  b_dout;
    logic        b_dout_valid;
    logic        b_oe;
    logic        b_busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [3:0] exp_q [$];

    nibbler_sync_ram #(.DATA_W(4), .ADDR_W(12), .CLEAR_ON_RESET(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .add(add), .din(din),
        .dout(dout), .dout_valid(dout_valid), .oe(oe), .busy(busy)
    );

    nibbler_sync_ram #(.DATA_W(4), .ADDR_W(12), .CLEAR_ON_RESET(1'b0)) dut_b (
        .clk(clk), .reset_n(b_reset_n), .cs(b_cs), .we(b_we), .add(b_add), .din(b_din),
        .dout(b_dout), .dout_valid(b_dout_valid), .oe(b_oe), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Every read pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset_n && dout_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(dout_valid), 32'd0);
            end else begin
                check("read_data", 32'(dout), 32'(exp_q.pop_front()));
            end
            check("oe_tracks_valid", 32'(oe), 32'(dout_valid));
        end
    end

    task automatic count_clear(input int stop_at, output int cnt);
        cnt = 0;
        while (busy && cnt < stop_at) begin
            cs  = (cnt == 100);
            we  = 1'b1;
            add = 12'h010;
            din = 4'hA;
            @(negedge clk);
            cnt++;
        end
        cs = 1'b0;
    endtask

    task automatic read_one(input logic [11:0] a, input logic [3:0] exp);
        cs  = 1'b1;
        we  = 1'b0;
        add = a;
        exp_q.push_back(exp);
        @(negedge clk);
        check("read_valid_latency", 32'(dout_valid), 32'd1);
        cs = 1'b0;
        @(negedge clk);
        check("read_valid_single", 32'(dout_valid), 32'd0);
    endtask

    initial begin
        int cnt;
        reset_n   = 1'b0;
        cs        = 1'b0;
        we        = 1'b0;
        add       = '0;
        din       = '0;
        b_reset_n = 1'b0;
        b_cs      = 1'b0;
        b_we      = 1'b0;
        b_add     = '0;
        b_din     = '0;
        repeat (3) @(negedge clk);

        check("rst_dout", 32'(dout), 32'd0);
        check("rst_valid", 32'(dout_valid), 32'd0);
        check("rst_oe", 32'(oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        check("b_rst_busy", 32'(b_busy), 32'd0);

        // Non-clearing instance: contents survive a reset pulse.
        b_reset_n = 1'b1;
        @(negedge clk);
        b_cs  = 1'b1;
        b_we  = 1'b1;
        b_add = 12'hABC;
        b_din = 4'h9;
        @(negedge clk);
        b_cs      = 1'b0;
        b_reset_n = 1'b0;
        @(negedge clk);
        b_reset_n = 1'b1;
        #1;
        check("b_busy_after_reset", 32'(b_busy), 32'd0);
        @(negedge clk);
        b_cs  = 1'b1;
        b_we  = 1'b0;
        b_add = 12'hABC;
        @(negedge clk);
        check("b_read_valid", 32'(b_dout_valid), 32'd1);
        check("b_read_data", 32'(b_dout), 32'h9);
        b_cs = 1'b0;

        // Clearing instance: full clear, with a write attempted mid-clear.
        reset_n = 1'b1;
        count_clear(10000, cnt);
        check("clear_cycles", 32'(cnt), 32'd4096);
        read_one(12'h000, 4'h0);
        read_one(12'h7FF, 4'h0);
        read_one(12'hFFF, 4'h0);
        read_one(12'h010, 4'h0);

        // Write then read of the same address on the next edge.
        cs  = 1'b1;
        we  = 1'b1;
        add = 12'h123;
        din = 4'h5;
        @(negedge clk);
        check("wr_no_valid", 32'(dout_valid), 32'd0);
        we = 1'b0;
        exp_q.push_back(4'h5);
        @(negedge clk);
        check("rdw_valid", 32'(dout_valid), 32'd1);
        check("rdw_oe", 32'(oe), 32'd1);
        cs = 1'b0;
        @(negedge clk);
        check("hold_dout", 32'(dout), 32'h5);
        check("hold_valid", 32'(dout_valid), 32'd0);

        // Streaming writes then streaming reads.
        for (int i = 0; i < 16; i++) begin
            cs  = 1'b1;
            we  = 1'b1;
            add = 12'(i);
            din = 4'(i);
            @(negedge clk);
        end
        for (int i = 0; i < 16; i++) begin
            cs  = 1'b1;
            we  = 1'b0;
            add = 12'(i);
            exp_q.push_back(4'(i));
            @(negedge clk);
            check("stream_valid", 32'(dout_valid), 32'd1);
        end
        cs = 1'b0;
        @(negedge clk);
        check("stream_end_valid", 32'(dout_valid), 32'd0);

        // Asynchronous reset kills an in-flight read pulse.
        cs  = 1'b1;
        we  = 1'b0;
        add = 12'h123;
        @(posedge clk);
        #1;
        check("inflight_dout", 32'(dout), 32'h5);
        check("inflight_valid", 32'(dout_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("kill_valid", 32'(dout_valid), 32'd0);
        check("kill_oe", 32'(oe), 32'd0);
        check("kill_dout", 32'(dout), 32'd0);
        check("kill_busy", 32'(busy), 32'd1);
        cs = 1'b0;
        @(negedge clk);
        @(negedge clk);

        // Reset mid-clear restarts the full sequence.
        reset_n = 1'b1;
        count_clear(2000, cnt);
        check("partial_clear_cycles", 32'(cnt), 32'd2000);
        reset_n = 1'b0;
        #1;
        check("midclr_busy", 32'(busy), 32'd1);
        check("midclr_valid", 32'(dout_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        count_clear(10000, cnt);
        check("restart_clear_cycles", 32'(cnt), 32'd4096);
        read_one(12'h123, 4'h0);
        read_one(12'h00F, 4'h0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
